// File: rtl/gm64_timing_pkg.sv
// gm64_timing_pkg
//   Shared timing constants and types for the C64 system timing stage.
//   PAL raster geometry, raster counter widths and the 6510 reset-hold
//   state encoding used by phi_clk_en_gen and raster_counter.
package gm64_timing_pkg;

  localparam int PAL_CYCLES_PER_LINE = 63;
  localparam int PAL_LINES_PER_FRAME = 312;
  localparam int RASTER_X_W          = 7;
  localparam int RASTER_Y_W          = 9;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } cpu_rst_state_e;

endpackage

// File: rtl/raster_counter.sv
// raster_counter
//   PAL raster position counter. Advances one PHI cycle per adv_i strobe,
//   wrapping x into the next line and y into the next frame. frame_ce_o is
//   high for the single clk following the wrap back to (0,0).
// Ports
//   clk         in   system clock
//   rst_n       in   async active-low reset
//   adv_i       in   advance strobe (one per PHI cycle)
//   raster_x_o  out  PHI cycle within line
//   raster_y_o  out  line within frame
//   frame_ce_o  out  1-clk strobe after the frame wrap
module raster_counter
  import gm64_timing_pkg::*;
#(
  parameter int CYCLES_PER_LINE = PAL_CYCLES_PER_LINE,
  parameter int LINES_PER_FRAME = PAL_LINES_PER_FRAME
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  adv_i,
  output logic [RASTER_X_W-1:0] raster_x_o,
  output logic [RASTER_Y_W-1:0] raster_y_o,
  output logic                  frame_ce_o
);

  localparam logic [RASTER_X_W-1:0] X_LAST = RASTER_X_W'(CYCLES_PER_LINE - 1);
  localparam logic [RASTER_Y_W-1:0] Y_LAST = RASTER_Y_W'(LINES_PER_FRAME - 1);

  logic [RASTER_X_W-1:0] x_q, x_d;
  logic [RASTER_Y_W-1:0] y_q, y_d;
  logic                  frame_q, frame_d;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    frame_d = 1'b0;
    if (adv_i) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d     = '0;
          frame_d = 1'b1;
        end else begin
          y_d = y_q + RASTER_Y_W'(1);
        end
      end else begin
        x_d = x_q + RASTER_X_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
    end
  end

  assign raster_x_o = x_q;
  assign raster_y_o = y_q;
  assign frame_ce_o = frame_q;

endmodule

// File: rtl/phi_clk_en_gen.sv
// phi_clk_en_gen
//   C64 system timing stage. Divides clk into PHI1/PHI2 phase strobes,
//   the 6510 clock enable and a PAL raster position, and holds the 6510 in
//   reset for RESET_HOLD PHI cycles after system reset or a soft-reset request.
//   Optional single-step support is compiled in with `define GM64_PHI_STEP_EN.
// Ports
//   clk            in   system clock
//   reset          in   async active-low system reset
//   cpu_reset_req  in   sync soft-reset request, active-high
//   step_mode      in   (GM64_PHI_STEP_EN) halt divider at PHI cycle start
//   step           in   (GM64_PHI_STEP_EN) release one PHI cycle
//   phi2           out  PHI2 level
//   phi1_ce        out  strobe at start of PHI1
//   phi2_ce        out  strobe at start of PHI2
//   cpu_ce         out  strobe on last clk of PHI2
//   cpu_reset_n    out  6510 reset, active-low
//   raster_x       out  PHI cycle within line
//   raster_y       out  line within frame
//   frame_ce       out  strobe after raster wraps to (0,0)
module phi_clk_en_gen
  import gm64_timing_pkg::*;
#(
  parameter int CLK_DIV         = 32,
  parameter int RESET_HOLD      = 8,
  parameter int CYCLES_PER_LINE = PAL_CYCLES_PER_LINE,
  parameter int LINES_PER_FRAME = PAL_LINES_PER_FRAME
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_reset_req,
`ifdef GM64_PHI_STEP_EN
  input  logic                  step_mode,
  input  logic                  step,
`endif
  output logic                  phi2,
  output logic                  phi1_ce,
  output logic                  phi2_ce,
  output logic                  cpu_ce,
  output logic                  cpu_reset_n,
  output logic [RASTER_X_W-1:0] raster_x,
  output logic [RASTER_Y_W-1:0] raster_y,
  output logic                  frame_ce
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  logic                 run_q;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic                 halt;
  logic                 adv;
  cpu_rst_state_e       state_q, state_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;

  // run goes high on the first edge after reset release so the first
  // phi1_ce appears one clk after release, never during reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

`ifdef GM64_PHI_STEP_EN
  logic stepping_q, stepping_d;

  // In step mode the divider parks at 0; a step only counts while parked,
  // so a step during an in-flight cycle is ignored. The cycle ends on cpu_ce.
  assign halt = step_mode & ~stepping_q & (div_cnt_q == '0);

  always_comb begin
    stepping_d = stepping_q;
    if (run_q && halt && step) stepping_d = 1'b1;
    else if (cpu_ce)           stepping_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stepping_q <= 1'b0;
    else        stepping_q <= stepping_d;
  end
`else
  assign halt = 1'b0;
`endif

  assign adv = run_q & ~halt;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (adv) begin
      if (div_cnt_q == DIV_LAST) div_cnt_d = '0;
      else                       div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_cnt_q <= '0;
    else        div_cnt_q <= div_cnt_d;
  end

  // Only the div_cnt==0 slot can be parked, so only phi1_ce needs the halt gate.
  assign phi1_ce = adv & (div_cnt_q == '0);
  assign phi2_ce = run_q & (div_cnt_q == DIV_HALF);
  assign cpu_ce  = run_q & (div_cnt_q == DIV_LAST);
  assign phi2    = run_q & (div_cnt_q >= DIV_HALF);

  // A request always restarts the hold, even on the cpu_ce that would
  // otherwise have completed it.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      HOLD: begin
        if (cpu_reset_req) begin
          hold_cnt_d = '0;
        end else if (cpu_ce) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = RUN;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
      RUN: begin
        if (cpu_reset_req) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign cpu_reset_n = (state_q == RUN);

  raster_counter #(
    .CYCLES_PER_LINE (CYCLES_PER_LINE),
    .LINES_PER_FRAME (LINES_PER_FRAME)
  ) u_raster (
    .clk        (clk),
    .rst_n      (reset),
    .adv_i      (cpu_ce),
    .raster_x_o (raster_x),
    .raster_y_o (raster_y),
    .frame_ce_o (frame_ce)
  );

endmodule

// File: tb/tb_phi_clk_en_gen.sv
// tb_phi_clk_en_gen
//   Directed bench for phi_clk_en_gen. A default-parameter instance covers
//   phases, reset hold, soft reset, line wrap and async reset; a small-geometry
//   instance (CLK_DIV=4, 5x4 raster) covers frame wrap in a short run.
//   Expected values derive from k = clk count since reset release.
module tb_phi_clk_en_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       cpu_reset_req;
  logic       phi2_m, phi1_ce_m, phi2_ce_m, cpu_ce_m, cpu_reset_n_m, frame_ce_m;
  logic [6:0] raster_x_m;
  logic [8:0] raster_y_m;
  logic       phi2_s, phi1_ce_s, phi2_ce_s, cpu_ce_s, cpu_reset_n_s, frame_ce_s;
  logic [6:0] raster_x_s;
  logic [8:0] raster_y_s;
`ifdef GM64_PHI_STEP_EN
  logic       step_mode, step;
  logic       step_off = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int k = 0;

  wire [3:0] ph_m = {phi2_m, phi1_ce_m, phi2_ce_m, cpu_ce_m};
  wire [3:0] ph_s = {phi2_s, phi1_ce_s, phi2_ce_s, cpu_ce_s};
  wire [20:0] all_m = {ph_m, cpu_reset_n_m, raster_x_m, raster_y_m, frame_ce_m};
  wire [20:0] all_s = {ph_s, cpu_reset_n_s, raster_x_s, raster_y_s, frame_ce_s};

  phi_clk_en_gen u_main (
    .clk(clk), .reset(reset), .cpu_reset_req(cpu_reset_req),
`ifdef GM64_PHI_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .phi2(phi2_m), .phi1_ce(phi1_ce_m), .phi2_ce(phi2_ce_m), .cpu_ce(cpu_ce_m),
    .cpu_reset_n(cpu_reset_n_m), .raster_x(raster_x_m), .raster_y(raster_y_m),
    .frame_ce(frame_ce_m)
  );

  phi_clk_en_gen #(.CLK_DIV(4), .RESET_HOLD(2), .CYCLES_PER_LINE(5), .LINES_PER_FRAME(4)) u_small (
    .clk(clk), .reset(reset), .cpu_reset_req(cpu_reset_req),
`ifdef GM64_PHI_STEP_EN
    .step_mode(step_off), .step(step_off),
`endif
    .phi2(phi2_s), .phi1_ce(phi1_ce_s), .phi2_ce(phi2_ce_s), .cpu_ce(cpu_ce_s),
    .cpu_reset_n(cpu_reset_n_s), .raster_x(raster_x_s), .raster_y(raster_y_s),
    .frame_ce(frame_ce_s)
  );

  // Reference model: k-th clk after release sees div_cnt = (k-1) % div.
  function automatic logic [3:0] exp_phase(int kk, int div);
    int c;
    if (kk < 1) return 4'b0000;
    c = (kk - 1) % div;
    return {c >= div / 2, c == 0, c == div / 2, c == div - 1};
  endfunction

  // Number of completed PHI cycles (cpu_ce edges) seen by the k-th clk.
  function automatic int exp_n(int kk, int div);
    return (kk < 1) ? 0 : (kk - 1) / div;
  endfunction

  function automatic logic exp_frame(int kk, int div, int per_frame);
    return (kk > 1) && ((kk - 1) % div == 0) && (exp_n(kk, div) % per_frame == 0);
  endfunction

  task automatic tick;
    @(negedge clk);
    k = k + 1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    cpu_reset_req = 1'b0;
    repeat (100) @(negedge clk);
    tests++;
    if (all_m !== 21'd0) begin
      fails++; $display("FAIL reset_main got %h exp 0", all_m);
    end
    tests++;
    if (all_s !== 21'd0) begin
      fails++; $display("FAIL reset_small got %h exp 0", all_s);
    end
    reset = 1'b1;
    k = 0;
  endtask

  task automatic test_phase;
    int hi = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (k <= 32 && phi2_m) hi++;
      tests++;
      if (ph_m !== exp_phase(k, 32)) begin
        fails++; $display("FAIL phase k=%0d got %b exp %b", k, ph_m, exp_phase(k, 32));
      end
    end
    tests++;
    if (hi !== 16) begin
      fails++; $display("FAIL phi2_duty got %0d exp 16", hi);
    end
  endtask

  task automatic test_cpu_reset_hold;
    while (k < 300) begin
      tick();
      tests++;
      if (cpu_reset_n_m !== (exp_n(k, 32) >= 8)) begin
        fails++; $display("FAIL hold k=%0d got %b exp %b", k, cpu_reset_n_m, exp_n(k, 32) >= 8);
      end
    end
  endtask

  task automatic test_raster_line;
    while (k < 2100) begin
      tick();
      tests++;
      if ({raster_x_m, raster_y_m, frame_ce_m} !==
          {7'(exp_n(k, 32) % 63), 9'(exp_n(k, 32) / 63 % 312), exp_frame(k, 32, 63 * 312)}) begin
        fails++; $display("FAIL raster k=%0d got x=%0d y=%0d f=%b", k, raster_x_m, raster_y_m, frame_ce_m);
      end
    end
  endtask

  task automatic test_soft_reset;
    int k0, m;
    while ((k - 1) % 32 != 5) tick();
    cpu_reset_req = 1'b1;
    tick();
    cpu_reset_req = 1'b0;
    k0 = k - 1;
    m = k0 - 6 + 32;
    while (k < m + 260) begin
      tests++;
      if (cpu_reset_n_m !== (k >= m + 225)) begin
        fails++; $display("FAIL soft_rst k=%0d got %b exp %b", k, cpu_reset_n_m, k >= m + 225);
      end
      tests++;
      if ({ph_m, raster_x_m} !== {exp_phase(k, 32), 7'(exp_n(k, 32) % 63)}) begin
        fails++; $display("FAIL soft_rst_timing k=%0d got %b/%0d", k, ph_m, raster_x_m);
      end
      tick();
    end
  endtask

  task automatic test_req_during_hold;
    int k0, m;
    while ((k - 1) % 32 != 10) tick();
    cpu_reset_req = 1'b1;
    tick();
    cpu_reset_req = 1'b0;
    k0 = k - 1;
    m = k0 - 11 + 32;
    while (k < m + 224) tick();
    tests++;
    if ({cpu_ce_m, cpu_reset_n_m} !== 2'b10) begin
      fails++; $display("FAIL req_hold_pre got %b exp 10", {cpu_ce_m, cpu_reset_n_m});
    end
    // Request on the cpu_ce that would complete the hold: hold must restart.
    cpu_reset_req = 1'b1;
    tick();
    cpu_reset_req = 1'b0;
    while (k < m + 500) begin
      tests++;
      if (cpu_reset_n_m !== (k >= m + 481)) begin
        fails++; $display("FAIL req_wins k=%0d got %b exp %b", k, cpu_reset_n_m, k >= m + 481);
      end
      tick();
    end
  endtask

  task automatic test_frame_wrap;
    int seen = 0;
    int want = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (frame_ce_s) seen++;
      if (exp_frame(k, 4, 20)) want++;
      tests++;
      if ({ph_s, raster_x_s, raster_y_s, frame_ce_s} !==
          {exp_phase(k, 4), 7'(exp_n(k, 4) % 5), 9'(exp_n(k, 4) / 5 % 4), exp_frame(k, 4, 20)}) begin
        fails++; $display("FAIL frame k=%0d got ph=%b x=%0d y=%0d f=%b", k, ph_s, raster_x_s, raster_y_s, frame_ce_s);
      end
    end
    tests++;
    if (seen !== want || want < 2) begin
      fails++; $display("FAIL frame_count got %0d exp %0d", seen, want);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    k = 0;
    while (k < 981) tick();
    tests++;
    if ({ph_m, raster_x_m} !== {4'b1000, 7'd30}) begin
      fails++; $display("FAIL async_pre got %b/%0d exp 1000/30", ph_m, raster_x_m);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (all_m !== 21'd0) begin
      fails++; $display("FAIL async_main got %h exp 0", all_m);
    end
    tests++;
    if (all_s !== 21'd0) begin
      fails++; $display("FAIL async_small got %h exp 0", all_s);
    end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    k = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      tests++;
      if ({ph_m, cpu_reset_n_m, raster_x_m} !==
          {exp_phase(k, 32), exp_n(k, 32) >= 8, 7'(exp_n(k, 32) % 63)}) begin
        fails++; $display("FAIL restart k=%0d got %b/%b/%0d", k, ph_m, cpu_reset_n_m, raster_x_m);
      end
    end
  endtask

`ifdef GM64_PHI_STEP_EN
  task automatic test_step;
    int n1 = 0, n2 = 0, nc = 0;
    @(negedge clk);
    reset = 1'b0;
    step_mode = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      tests++;
      if ({ph_m, raster_x_m} !== 11'd0) begin
        fails++; $display("FAIL step_halt got %b/%0d exp 0000/0", ph_m, raster_x_m);
      end
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (phi1_ce_m) n1++;
      if (phi2_ce_m) n2++;
      if (cpu_ce_m)  nc++;
      @(negedge clk);
    end
    tests++;
    if ({n1, n2, nc} !== {32'd1, 32'd1, 32'd1}) begin
      fails++; $display("FAIL step_count got %0d/%0d/%0d exp 1/1/1", n1, n2, nc);
    end
    tests++;
    if ({ph_m, raster_x_m} !== {4'b0000, 7'd1}) begin
      fails++; $display("FAIL step_end got %b/%0d exp 0000/1", ph_m, raster_x_m);
    end
    step_mode = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b0;
    cpu_reset_req = 1'b0;
`ifdef GM64_PHI_STEP_EN
    step_mode = 1'b0;
    step = 1'b0;
`endif
    test_reset();
    test_phase();
    test_cpu_reset_hold();
    test_raster_line();
    test_soft_reset();
    test_req_during_hold();
    test_frame_wrap();
    test_async_reset();
`ifdef GM64_PHI_STEP_EN
    test_step();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
